adder_vector_checker: RTL and testbench
=======================================

Name: adder_vector_checker

Overview:
- Self-checking stimulus/response engine for the adder test wrapper. Sits on the opposite side of that wrapper's interface.
- Drives operand pairs A/B and the path select Sel, generated from a seeded LFSR.
- Captures the registered 40-bit Result after a fixed pipeline latency and compares it with a locally computed sum.
- Reports pass/fail, an error count and the first failing vector, so the adder comparisons run on-board without a host.

Parameters:
- LATENCY, 3: clock edges from the edge that updates A/B to the edge that samples the matching Result. The wrapper needs 3: operand register, result register, then the sample edge. Legal range 1..8.
- TAPS, 32'h8020_0003: Galois LFSR feedback mask for x^32+x^22+x^2+x+1.

Ports:
- clk  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-high reset
- start  input  1  begin a run; sampled only in IDLE
- sel_cfg  input  1  path select for the run; latched at start
- seed  input  32  LFSR seed; latched at start
- num_vec  input  16  vectors to issue; latched at start
- A  output  32  operand A to the DUT, registered
- B  output  32  operand B to the DUT, registered
- Sel  output  1  path select to the DUT, registered, held for the whole run
- Result  input  40  registered DUT result
- busy  output  1  high in RUN and DRAIN
- done  output  1  high in DONE until the next accepted start
- pass  output  1  valid while done; 1 iff err_count==0
- err_count  output  16  mismatches, saturating at 16'hFFFF
- first_err_idx  output  16  index of the first mismatching vector
- first_err_got  output  40  Result captured at the first mismatch

Behaviour:
- Reset (asynchronous, RST=1): state=IDLE. A, B, Sel, busy, done, pass, err_count, first_err_idx, first_err_got, LFSR state, vector counter and expected-pipe valid bits all go to 0. Reset mid-run aborts immediately; no partial result is retained.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE to RUN on start=1 (edge t0):
  - latch sel_cfg, num_vec and seed; a seed of 0 is replaced by 32'h0000_0001;
  - clear err_count, first_err_*, done and pass;
  - drive vector 0.
- If num_vec==0 at start: go directly to DONE at t0 with pass=1 and nothing issued.
- start while busy is ignored.
- Vector k, driven at edge t0+k:
  - A = s_k, where s_0 = seed;
  - B = {s_k[15:0], s_k[31:16]} ^ 32'h5A5A_5A5A;
  - s_(k+1) = s_k[0] ? ((s_k>>1) ^ TAPS) : (s_k>>1).
- One vector per cycle; no backpressure.
- Expected value = {7'b0, A+B}, with the 33-bit sum zero-extended.
- Expected value, valid flag and index are pushed into a LATENCY-deep shift pipe at the same edge A/B update.
- Comparison at edge t0+k+LATENCY: if valid and Result != expected, err_count increments (saturating).
- On the first mismatch of a run, first_err_idx=k and first_err_got=Result are captured; later mismatches do not overwrite them.
- After vector num_vec-1 is issued, RUN goes to DRAIN:
  - A, B and Sel hold their last values;
  - zeros enter the pipe's valid bits;
  - DRAIN lasts until the last compare edge t0+num_vec-1+LATENCY.
- DRAIN to DONE one edge after the last compare, at t0+num_vec+LATENCY:
  - busy=0, done=1, pass=(err_count==0).
- A compare and a state transition on the same edge: the compare takes effect first, so the final err_count already includes the last vector.
- Sel stays at sel_cfg in RUN, DRAIN and DONE; it returns to 0 only on reset.

Test Plan:
- Ideal 3-edge adder model, seed=1, num_vec=16, sel_cfg=1 -> A0=32'h0000_0001, B0=32'h5A5B_5A5A, A1=32'h8020_0003; done rises at t0+19; pass=1; err_count=0; Sel=1 throughout.
- Same model, with the Result of vector 5 forced +1 -> err_count=1, first_err_idx=5, first_err_got=expected5+1, pass=0.
- seed=0, num_vec=1 -> A0=32'h0000_0001 (seed substituted); done at t0+4; pass=1.
- num_vec=0 -> done=1 and pass=1 right after edge t0; busy never asserts; A and B remain 0.
- Model that always returns 0, num_vec=16'hFFFF -> err_count=16'hFFFF with no wrap; first_err_idx=0.
- RST pulsed at t0+7 of a 16-vector run -> all outputs 0 and state IDLE; a new start then runs cleanly with pass=1.

Source files
------------

// File: rtl/adder_vector_checker_if.sv
// adder_vector_checker_if: operand/result bus between the checker and the adder wrapper
interface adder_vector_checker_if;
  logic [31:0] A;
  logic [31:0] B;
  logic        Sel;
  logic [39:0] Result;
  modport master (output A, B, Sel, input Result);
  modport slave (input A, B, Sel, output Result);
endinterface

// File: rtl/adder_vector_checker.sv
// adder_vector_checker: LFSR-driven operand generator that checks adder results after a fixed latency
module adder_vector_checker #(
  parameter int          LATENCY = 3,
  parameter logic [31:0] TAPS    = 32'h8020_0003
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   start,
  input  logic                   sel_cfg,
  input  logic [31:0]            seed,
  input  logic [15:0]            num_vec,
  adder_vector_checker_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [15:0]            err_count,
  output logic [15:0]            first_err_idx,
  output logic [39:0]            first_err_got
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [31:0] lfsr, cur, nb;
  logic [32:0] sum;
  logic [15:0] cnt, num, idx;
  logic go, issue, mis;
  logic [LATENCY-1:0] pv;
  logic [39:0] pe [LATENCY];
  logic [15:0] pi [LATENCY];
  always_comb begin
    go = start && (state == IDLE || state == DONE);
    cur = go ? (seed == 32'd0 ? 32'd1 : seed) : lfsr;
    nb = {cur[15:0], cur[31:16]} ^ 32'h5A5A_5A5A;
    sum = {1'b0, cur} + {1'b0, nb};
    idx = go ? 16'd0 : cnt;
    issue = (go && num_vec != 16'd0) || state == RUN;
    mis = pv[LATENCY-1] && bus.Result != pe[LATENCY-1];
    busy = state == RUN || state == DRAIN;
    done = state == DONE;
    pass = done && err_count == 16'd0;
    state_n = state;
    if (go)
      state_n = num_vec == 16'd0 ? DONE : num_vec == 16'd1 ? DRAIN : RUN;
    else if (state == RUN && cnt == num - 16'd1)
      state_n = DRAIN;
    else if (state == DRAIN && pv == '0)
      state_n = DONE;
  end
  always_ff @(posedge clk or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_n;
  // The compare uses the oldest pipe entry, so it always lands before any state change on the same edge
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      bus.A <= '0;
      bus.B <= '0;
      bus.Sel <= 1'b0;
      lfsr <= '0;
      cnt <= '0;
      num <= '0;
      err_count <= '0;
      first_err_idx <= '0;
      first_err_got <= '0;
      pv <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pe[i] <= '0;
        pi[i] <= '0;
      end
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pi[i] <= pi[i-1];
      end
      pv[0] <= issue;
      pe[0] <= {7'b0, sum};
      pi[0] <= idx;
      if (issue) begin
        bus.A <= cur;
        bus.B <= nb;
        lfsr <= cur[0] ? ((cur >> 1) ^ TAPS) : (cur >> 1);
        cnt <= idx + 16'd1;
      end
      if (go) begin
        bus.Sel <= sel_cfg;
        num <= num_vec;
        err_count <= '0;
        first_err_idx <= '0;
        first_err_got <= '0;
      end else if (mis) begin
        err_count <= err_count + {15'd0, err_count != 16'hFFFF};
        if (err_count == 16'd0) begin
          first_err_idx <= pi[LATENCY-1];
          first_err_got <= bus.Result;
        end
      end
    end
  end
endmodule

// File: tb/tb_adder_vector_checker.sv
// tb_adder_vector_checker: directed checks of the checker against a clocked adder wrapper model
module tb_adder_vector_checker;
  logic clk = 1'b0;
  logic RST = 1'b1;
  logic start = 1'b0;
  logic sel_cfg = 1'b0;
  logic [31:0] seed = '0;
  logic [15:0] num_vec = '0;
  logic busy, done, pass;
  logic [15:0] err_count, first_err_idx;
  logic [39:0] first_err_got;
  int checks = 0;
  int errors = 0;
  int mode = 0;
  logic [31:0] ra = '0, rb = '0, a5, b5;
  logic [39:0] exp5;
  adder_vector_checker_if bus ();
  adder_vector_checker dut (
    .clk(clk), .RST(RST), .start(start), .sel_cfg(sel_cfg), .seed(seed), .num_vec(num_vec),
    .bus(bus), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_got(first_err_got)
  );
  always #5 clk = ~clk;
  // Wrapper model: operand register then result register; mode 1 corrupts vector 5, mode 2 returns 0
  always @(posedge clk) begin
    ra <= bus.A;
    rb <= bus.B;
    bus.Result <= mode == 2 ? 40'd0 :
      {7'b0, {1'b0, ra} + {1'b0, rb}} + ((mode == 1 && ra == a5) ? 40'd1 : 40'd0);
  end
  function automatic logic [31:0] nxt(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction
  task automatic start_run(input logic [31:0] s, input logic [15:0] n, input logic sl);
    @(negedge clk);
    seed = s;
    num_vec = n;
    sel_cfg = sl;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask
  task automatic wait_done(input int budget, output int k);
    k = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        k = i;
        break;
      end
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({bus.A, bus.B, bus.Sel, busy, done, pass} !== '0) begin
      errors++;
      $display("FAIL reset_bus got A=%h B=%h Sel=%b busy=%b done=%b pass=%b want all 0",
               bus.A, bus.B, bus.Sel, busy, done, pass);
    end
    checks++;
    if ({err_count, first_err_idx, first_err_got} !== '0) begin
      errors++;
      $display("FAIL reset_status got err=%h idx=%h got=%h want 0", err_count, first_err_idx, first_err_got);
    end
  endtask
  task automatic test_ideal();
    int k;
    int sel_bad;
    mode = 0;
    start_run(32'd1, 16'd16, 1'b1);
    checks++;
    if (bus.A !== 32'h0000_0001 || bus.B !== 32'h5A5B_5A5A) begin
      errors++;
      $display("FAIL ideal_v0 got A=%h B=%h want A=00000001 B=5a5b5a5a", bus.A, bus.B);
    end
    k = -1;
    sel_bad = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        checks++;
        if (bus.A !== 32'h8020_0003) begin
          errors++;
          $display("FAIL ideal_v1 got A=%h want 80200003", bus.A);
        end
      end
      if (bus.Sel !== 1'b1) sel_bad++;
      if (done) begin
        k = i;
        break;
      end
    end
    checks++;
    if (sel_bad != 0) begin
      errors++;
      $display("FAIL ideal_sel got %0d cycles with Sel!=1 want 0", sel_bad);
    end
    checks++;
    if (k != 19) begin
      errors++;
      $display("FAIL ideal_done_time got %0d want 19", k);
    end
    checks++;
    if (pass !== 1'b1 || err_count !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ideal_result got pass=%b err=%h busy=%b want 1 0 0", pass, err_count, busy);
    end
  endtask
  task automatic test_mismatch();
    int k;
    mode = 1;
    start_run(32'd1, 16'd16, 1'b1);
    wait_done(40, k);
    checks++;
    if (k != 19 || err_count !== 16'd1 || pass !== 1'b0) begin
      errors++;
      $display("FAIL mis_count got t=%0d err=%h pass=%b want 19 1 0", k, err_count, pass);
    end
    checks++;
    if (first_err_idx !== 16'd5 || first_err_got !== exp5) begin
      errors++;
      $display("FAIL mis_first got idx=%h val=%h want 0005 %h", first_err_idx, first_err_got, exp5);
    end
    mode = 0;
  endtask
  task automatic test_seed_zero();
    int k;
    start_run(32'd0, 16'd1, 1'b0);
    checks++;
    if (bus.A !== 32'h0000_0001 || bus.B !== 32'h5A5B_5A5A || bus.Sel !== 1'b0) begin
      errors++;
      $display("FAIL seed0_v0 got A=%h B=%h Sel=%b want 00000001 5a5b5a5a 0", bus.A, bus.B, bus.Sel);
    end
    wait_done(20, k);
    checks++;
    if (k != 4 || pass !== 1'b1) begin
      errors++;
      $display("FAIL seed0_done got t=%0d pass=%b want 4 1", k, pass);
    end
  endtask
  task automatic test_zero_vec();
    int busy_seen;
    do_reset();
    start_run(32'h1234_5678, 16'd0, 1'b1);
    busy_seen = busy ? 1 : 0;
    checks++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      errors++;
      $display("FAIL zero_done got done=%b pass=%b want 1 1", done, pass);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (busy) busy_seen++;
    end
    checks++;
    if (busy_seen != 0 || bus.A !== 32'd0 || bus.B !== 32'd0) begin
      errors++;
      $display("FAIL zero_idle got busy_cycles=%0d A=%h B=%h want 0 0 0", busy_seen, bus.A, bus.B);
    end
  endtask
  task automatic test_saturate();
    int k;
    mode = 2;
    start_run(32'hACE1_0001, 16'hFFFF, 1'b1);
    wait_done(70000, k);
    checks++;
    if (k != 65538 || err_count !== 16'hFFFF || pass !== 1'b0) begin
      errors++;
      $display("FAIL sat_count got t=%0d err=%h pass=%b want 65538 ffff 0", k, err_count, pass);
    end
    checks++;
    if (first_err_idx !== 16'd0) begin
      errors++;
      $display("FAIL sat_first got idx=%h want 0000", first_err_idx);
    end
    mode = 0;
  endtask
  task automatic test_reset_midrun();
    int k;
    start_run(32'hDEAD_BEEF, 16'd16, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    RST = 1'b1;
    #1;
    checks++;
    if ({bus.A, bus.B, bus.Sel, busy, done, pass, err_count, first_err_idx, first_err_got} !== '0) begin
      errors++;
      $display("FAIL midrst_clear got A=%h B=%h Sel=%b busy=%b done=%b err=%h want all 0",
               bus.A, bus.B, bus.Sel, busy, done, err_count);
    end
    @(negedge clk);
    RST = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle got busy=%b done=%b want 0 0", busy, done);
    end
    start_run(32'd1, 16'd16, 1'b1);
    wait_done(40, k);
    checks++;
    if (k != 19 || pass !== 1'b1 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL midrst_rerun got t=%0d pass=%b err=%h want 19 1 0", k, pass, err_count);
    end
  endtask
  initial begin
    a5 = 32'd1;
    for (int i = 0; i < 5; i++) a5 = nxt(a5);
    b5 = {a5[15:0], a5[31:16]} ^ 32'h5A5A_5A5A;
    exp5 = {7'b0, {1'b0, a5} + {1'b0, b5}} + 40'd1;
    test_reset();
    test_ideal();
    test_mismatch();
    test_seed_zero();
    test_zero_vec();
    test_saturate();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
